checkbits_monitor: RTL and testbench
====================================

Name: checkbits_monitor

Overview:
Synthesizable FPGA-side monitor for the Caravel SoC on the FPGA platform. It consumes the mprj_io[31:16] checkbits that firmware drives on the user GPIOs. It debounces the checkbits, tracks a start-code then pass-code handshake with a cycle-count timeout, and exposes sticky status for LEDs and the host. It replaces the simulation-only wait() monitor so that firmware runs booted from BRAM through the SPI flash model can be judged on hardware.

Parameters:
WIDTH, 16, checkbits width
START_CODE, 16'hAB60, code marking firmware start
PASS_CODE, 16'hAB61, code marking test pass
STABLE_CYCLES, 4, consecutive equal samples needed to accept a value (legal range 2..255)
TIMEOUT_CYCLES, 700000, cycles from reset/clear to timeout (at least 2)
TMO_W, 20, elapsed counter width (2^TMO_W > TIMEOUT_CYCLES)

Ports:
ap_clk  in  1  clock (same as the SoC clock)
ap_rst  in  1  synchronous reset, active-low
checkbits_in  in  WIDTH  mprj_io[31:16], asynchronous to internal logic
clear  in  1  synchronous restart, active-high
started  out  1  START_CODE accepted (sticky)
passed  out  1  PASS_CODE accepted after start (sticky)
timeout  out  1  timeout expired before pass (sticky)
done  out  1  passed | timeout
last_code  out  WIDTH  most recently accepted stable value
change_count  out  8  number of accepted value changes, saturating at 255
elapsed  out  TMO_W  cycles spent in IDLE/RUN, frozen in terminal states

Behaviour:
- Reset: ap_rst sampled low on a rising edge sets all registers, the synchronizer and all outputs to 0, and puts the FSM in IDLE. clear=1 has the same effect except that the synchronizer is kept. Reset or clear takes effect mid-operation in any state.
- Input path: 2-flop synchronizer s1 then s2, with no reset dependency on data.
- Stability filter: registers cand and cnt (8-bit).
  - If s2 != cand: cand <= s2, cnt <= 1.
  - Else if cnt < STABLE_CYCLES: cnt increments. The edge on which cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES is the accept edge.
  - Else: cnt holds, so a value is not re-accepted.
- Accept latency: an input held constant from before edge 0 is accepted on edge STABLE_CYCLES+2 (edge 6 at the default). Pulses shorter than STABLE_CYCLES synchronized cycles are never accepted.
- On the accept edge: last_code <= cand. If cand != last_code, change_count increments (saturating at 255). The FSM evaluates the accepted value on the same edge, so status outputs are registered with no extra cycle.
- FSM states: IDLE, RUN, PASS, TMO. Encoding is free.
  - IDLE: accept of START_CODE -> RUN (started=1). PASS_CODE and other codes are ignored.
  - RUN: accept of PASS_CODE -> PASS (passed=1). START_CODE again and other codes are ignored.
  - PASS and TMO: terminal. Only reset or clear leaves them. The filter, last_code and change_count keep updating in these states.
- Timeout:
  - elapsed increments every edge while in IDLE or RUN.
  - On an edge where elapsed == TIMEOUT_CYCLES-1 in IDLE or RUN: go to TMO (timeout=1) and hold elapsed.
  - If that same edge accepts PASS_CODE while in RUN, PASS wins: timeout stays 0.
- Outputs: done = passed | timeout, registered or derived combinationally from registered state. started stays 1 in PASS, and also in TMO if it was set before the timeout.

Test Plan:
Bench parameters: STABLE_CYCLES=4, TIMEOUT_CYCLES=200. Edges are counted from the input change.
- Reset: hold ap_rst=0 for 3 cycles with checkbits_in=16'h1234 -> all outputs 0. Release -> last_code=16'h1234 on edge 6, change_count=1.
- Normal pass: 0000 for 10 cycles, AB60 for 20 cycles, then AB61.
  - started=1 exactly on edge 6 after AB60.
  - passed=1 and done=1 on edge 6 after AB61.
  - last_code=AB61, change_count=2, timeout=0.
- Glitch rejection: AB60 for 3 cycles then 0000 -> started stays 0, change_count stays 0. AB60 held for 4 cycles -> started=1.
- Out-of-order: AB61 for 20 cycles, then AB60, then AB61.
  - passed stays 0 during the first AB61.
  - started=1 after AB60, then passed=1 after the second AB61.
  - change_count=3.
- Timeout: input constant at 0000 -> timeout=1 and done=1 on the edge where elapsed reaches 199. elapsed stays 199. A later AB60/AB61 leaves passed=0 and started=0.
- Pass/timeout collision and restart:
  - Arrange for the AB61 accept edge to coincide with elapsed==199 -> passed=1, timeout=0.
  - Then pulse clear for 1 cycle -> all status 0, elapsed=0 on the next edge.
  - Then pull ap_rst low for 1 cycle during RUN -> IDLE, outputs 0.

Source files
------------

// File: rtl/checkbits_monitor.sv
// Hardware monitor for Caravel firmware checkbits on mprj_io[31:16]: it debounces the value,
// follows the start-code/pass-code handshake with a cycle timeout, and keeps sticky status.
module checkbits_monitor #(
    parameter int unsigned      WIDTH          = 16,
    parameter logic [WIDTH-1:0] START_CODE     = 16'hAB60,
    parameter logic [WIDTH-1:0] PASS_CODE      = 16'hAB61,
    parameter int unsigned      STABLE_CYCLES  = 4,
    parameter int unsigned      TIMEOUT_CYCLES = 700000,
    parameter int unsigned      TMO_W          = 20
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic [WIDTH-1:0] checkbits_in,
    input  logic             clear,
    output logic             started,
    output logic             passed,
    output logic             timeout,
    output logic             done,
    output logic [WIDTH-1:0] last_code,
    output logic [7:0]       change_count,
    output logic [TMO_W-1:0] elapsed
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PASS,
        TMO
    } state_t;

    localparam logic [7:0]       STABLE_N = 8'(STABLE_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] cand;
    logic [7:0]       cnt;
    logic             accept;
    logic             restart;

    state_t           state;
    state_t           state_next;
    logic             started_next;
    logic             passed_next;
    logic             timeout_next;
    logic [TMO_W-1:0] elapsed_next;
    logic             tmo_hit;

    assign restart = !ap_rst || clear;

    // clear restarts the monitor but leaves the synchronizer running
    always_ff @(posedge ap_clk) begin
        if (!ap_rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= checkbits_in;
            s2 <= s1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (restart) begin
            cand <= '0;
            cnt  <= '0;
        end else if (s2 != cand) begin
            cand <= s2;
            cnt  <= 8'd1;
        end else if (cnt < STABLE_N) begin
            cnt <= cnt + 8'd1;
        end
    end

    // cnt saturates at STABLE_N, so a held value is accepted exactly once
    assign accept = (s2 == cand) && (cnt == STABLE_N - 8'd1);

    always_ff @(posedge ap_clk) begin
        if (restart) begin
            last_code    <= '0;
            change_count <= '0;
        end else if (accept) begin
            last_code <= cand;
            if (cand != last_code && change_count != 8'hFF) begin
                change_count <= change_count + 8'd1;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (restart) begin
            state   <= IDLE;
            started <= 1'b0;
            passed  <= 1'b0;
            timeout <= 1'b0;
            elapsed <= '0;
        end else begin
            state   <= state_next;
            started <= started_next;
            passed  <= passed_next;
            timeout <= timeout_next;
            elapsed <= elapsed_next;
        end
    end

    assign tmo_hit = (elapsed == TMO_LAST);

    always_comb begin
        state_next   = state;
        started_next = started;
        passed_next  = passed;
        timeout_next = timeout;
        elapsed_next = elapsed;
        unique case (state)
            IDLE: begin
                if (tmo_hit) begin
                    state_next   = TMO;
                    timeout_next = 1'b1;
                end else begin
                    elapsed_next = elapsed + 1'b1;
                    if (accept && cand == START_CODE) begin
                        state_next   = RUN;
                        started_next = 1'b1;
                    end
                end
            end
            RUN: begin
                // a pass accepted on the final cycle beats the timeout
                if (accept && cand == PASS_CODE) begin
                    state_next   = PASS;
                    passed_next  = 1'b1;
                    elapsed_next = elapsed + 1'b1;
                end else if (tmo_hit) begin
                    state_next   = TMO;
                    timeout_next = 1'b1;
                end else begin
                    elapsed_next = elapsed + 1'b1;
                end
            end
            PASS: ;
            TMO: ;
            default: state_next = IDLE;
        endcase
    end

    assign done = passed | timeout;

endmodule

// File: tb/tb_checkbits_monitor.sv
// Self-checking bench for checkbits_monitor: directed handshake scenarios plus random code
// streams, compared every cycle against a history-based reference model.
module tb_checkbits_monitor;

    localparam int          S     = 4;
    localparam int          T     = 200;
    localparam logic [15:0] START = 16'hAB60;
    localparam logic [15:0] PASSC = 16'hAB61;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b0;
    logic        clear  = 1'b0;
    logic [15:0] checkbits_in = 16'h0;
    logic        started;
    logic        passed;
    logic        timeout;
    logic        done;
    logic [15:0] last_code;
    logic [7:0]  change_count;
    logic [19:0] elapsed;

    int checks = 0;
    int errors = 0;

    // Reference model: the synchronizer is a two-entry delay line, and a value is accepted
    // when the delayed sample stream ends in a run of exactly S equal samples.
    logic [15:0] pipe[$];
    logic [15:0] hist[$];
    logic        m_started;
    logic        m_passed;
    logic        m_timeout;
    logic [15:0] m_last;
    int          m_cc;
    int          m_elapsed;

    checkbits_monitor #(
        .WIDTH(16),
        .START_CODE(16'hAB60),
        .PASS_CODE(16'hAB61),
        .STABLE_CYCLES(S),
        .TIMEOUT_CYCLES(T),
        .TMO_W(20)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst(ap_rst),
        .checkbits_in(checkbits_in),
        .clear(clear),
        .started(started),
        .passed(passed),
        .timeout(timeout),
        .done(done),
        .last_code(last_code),
        .change_count(change_count),
        .elapsed(elapsed)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int trailing_run(input logic [15:0] v);
        int n;
        n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == v) n++;
            else break;
        end
        return n;
    endfunction

    task automatic model_clear();
        hist.delete();
        m_started = 1'b0;
        m_passed  = 1'b0;
        m_timeout = 1'b0;
        m_last    = 16'h0;
        m_cc      = 0;
        m_elapsed = 0;
    endtask

    task automatic model_edge();
        logic [15:0] x;
        bit          acc;
        bit          pass_now;
        if (!ap_rst) begin
            pipe = '{16'h0, 16'h0};
            model_clear();
            return;
        end
        x = pipe[0];
        void'(pipe.pop_front());
        pipe.push_back(checkbits_in);
        if (clear) begin
            model_clear();
            return;
        end
        hist.push_back(x);
        if (hist.size() > S + 1) void'(hist.pop_front());
        acc = (trailing_run(x) == S);
        if (acc) begin
            if (x != m_last && m_cc < 255) m_cc++;
            m_last = x;
        end
        if (!m_passed && !m_timeout) begin
            pass_now = m_started && acc && (x == PASSC);
            if (!pass_now && m_elapsed == T - 1) begin
                m_timeout = 1'b1;
            end else begin
                m_elapsed++;
                if (pass_now) m_passed = 1'b1;
                else if (!m_started && acc && x == START) m_started = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        chk("started",      32'(started),      32'(m_started));
        chk("passed",       32'(passed),       32'(m_passed));
        chk("timeout",      32'(timeout),      32'(m_timeout));
        chk("done",         32'(done),         32'(m_passed | m_timeout));
        chk("last_code",    32'(last_code),    32'(m_last));
        chk("change_count", 32'(change_count), 32'(m_cc));
        chk("elapsed",      32'(elapsed),      32'(m_elapsed));
    endtask

    task automatic cyc(input logic r, input logic c, input logic [15:0] code);
        ap_rst       = r;
        clear        = c;
        checkbits_in = code;
        @(posedge ap_clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        logic [15:0] code;
        int          hold;
        int          pick;
        int          r;
        pipe = '{16'h0, 16'h0};
        model_clear();

        // reset state, then first acceptance after release
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h1234);
        chk("rst_started", 32'(started), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_last", 32'(last_code), 32'd0);
        chk("rst_elapsed", 32'(elapsed), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 16'h1234);
            if (i == 5) chk("rel_last_e5", 32'(last_code), 32'd0);
            if (i == 6) chk("rel_last_e6", 32'(last_code), 32'h1234);
            if (i == 6) chk("rel_cc_e6", 32'(change_count), 32'd1);
        end

        // normal pass
        cyc(1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 16'h0);
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b1, 1'b0, START);
            if (i == 5) chk("np_started_e5", 32'(started), 32'd0);
            if (i == 6) chk("np_started_e6", 32'(started), 32'd1);
        end
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, PASSC);
            if (i == 5) chk("np_passed_e5", 32'(passed), 32'd0);
            if (i == 6) chk("np_passed_e6", 32'(passed), 32'd1);
            if (i == 6) chk("np_done_e6", 32'(done), 32'd1);
        end
        chk("np_last", 32'(last_code), 32'hAB61);
        chk("np_cc", 32'(change_count), 32'd2);
        chk("np_timeout", 32'(timeout), 32'd0);

        // glitch rejection
        cyc(1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, START);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 16'h0);
        chk("gl_started", 32'(started), 32'd0);
        chk("gl_cc", 32'(change_count), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, START);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 16'h0);
        chk("gl4_started", 32'(started), 32'd1);

        // pass code before start code
        cyc(1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, PASSC);
        chk("oo_passed_early", 32'(passed), 32'd0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, START);
        chk("oo_started", 32'(started), 32'd1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, PASSC);
        chk("oo_passed", 32'(passed), 32'd1);
        chk("oo_cc", 32'(change_count), 32'd3);

        // timeout
        cyc(1'b0, 1'b0, 16'h0);
        for (int i = 1; i <= 205; i++) begin
            cyc(1'b1, 1'b0, 16'h0);
            if (i == 199) chk("to_tmo_e199", 32'(timeout), 32'd0);
            if (i == 200) chk("to_tmo_e200", 32'(timeout), 32'd1);
            if (i == 200) chk("to_done_e200", 32'(done), 32'd1);
        end
        chk("to_elapsed", 32'(elapsed), 32'd199);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, START);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, PASSC);
        chk("to_late_started", 32'(started), 32'd0);
        chk("to_late_passed", 32'(passed), 32'd0);
        chk("to_elapsed_hold", 32'(elapsed), 32'd199);

        // pass accepted on the timeout edge, then clear, then reset during RUN
        cyc(1'b0, 1'b0, 16'h0);
        for (int i = 1; i <= 200; i++) begin
            if (i <= 10) cyc(1'b1, 1'b0, 16'h0);
            else if (i <= 194) cyc(1'b1, 1'b0, START);
            else cyc(1'b1, 1'b0, PASSC);
        end
        chk("col_passed", 32'(passed), 32'd1);
        chk("col_timeout", 32'(timeout), 32'd0);
        cyc(1'b1, 1'b1, PASSC);
        chk("clr_passed", 32'(passed), 32'd0);
        chk("clr_started", 32'(started), 32'd0);
        chk("clr_elapsed", 32'(elapsed), 32'd0);
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, START);
        chk("run_started", 32'(started), 32'd1);
        cyc(1'b0, 1'b0, START);
        chk("rrun_started", 32'(started), 32'd0);
        chk("rrun_elapsed", 32'(elapsed), 32'd0);

        // random code streams with occasional clear and reset
        cyc(1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 300; i++) begin
            pick = $urandom_range(0, 9);
            if (pick < 3) code = START;
            else if (pick < 6) code = PASSC;
            else if (pick < 8) code = 16'h0;
            else code = 16'($urandom);
            hold = $urandom_range(1, 8);
            for (int j = 0; j < hold; j++) begin
                r = $urandom_range(0, 199);
                cyc(r != 0, (r == 1 || r == 2), code);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
